// File: rtl/led_status_ind.sv
// led_status_ind: multi-channel LED indicator with off/on/slow/fast/burst modes on a shared prescaler tick.
module led_status_ind #(
  parameter int N_CH = 4,
  parameter int TICK_DIV = 2000000,
  parameter int RST_MODE = 2,
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1,
  localparam int PW = $clog2(TICK_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_ch,
  input  logic [2:0]      wr_mode,
  input  logic [3:0]      wr_count,
  input  logic            sync,
  output logic [N_CH-1:0] led,
  output logic            tick
);
  typedef enum logic [1:0] {ON, OFF, GAP} phase_t;
  logic [PW-1:0] pre;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || sync || tick) pre <= '0;
    else pre <= pre + 1'b1;
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [2:0] mode, mode_n;
    logic [3:0] count, count_n, seg, seg_n, pidx, pidx_n, len;
    phase_t ph, ph_n;
    logic we, rs, done, led_r, led_n;
    // Channels that cannot be addressed simply never match, so out-of-range writes are ignored.
    assign we = wr_en && wr_ch == CW'(i);
    assign rs = we || sync;
    always_comb begin
      mode_n = we ? (wr_mode > 3'd4 ? 3'd0 : wr_mode) : mode;
      count_n = we ? wr_count : count;
      len = ph == GAP ? 4'd8 : mode == 3'd2 ? 4'd5 : mode == 3'd3 ? 4'd1 : 4'd2;
      done = tick && seg + 4'd1 == len;
      ph_n = rs ? ON : !done ? ph : ph == ON ? OFF :
             (ph == OFF && mode == 3'd4 && pidx == count) ? GAP : ON;
      pidx_n = (rs || (done && ph == GAP)) ? 4'd1 : (done && ph == OFF) ? pidx + 4'd1 : pidx;
      seg_n = (rs || done) ? 4'd0 : tick ? seg + 4'd1 : seg;
      led_n = mode_n == 3'd1 ||
              ((mode_n == 3'd2 || mode_n == 3'd3 || (mode_n == 3'd4 && count_n != 4'd0)) && ph_n == ON);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        mode <= 3'(RST_MODE);
        count <= '0;
        seg <= '0;
        pidx <= 4'd1;
        ph <= ON;
        led_r <= RST_MODE inside {1, 2, 3};
      end else begin
        mode <= mode_n;
        count <= count_n;
        seg <= seg_n;
        pidx <= pidx_n;
        ph <= ph_n;
        led_r <= led_n;
      end
    end
    assign led[i] = led_r;
  end
endmodule

// File: tb/tb_led_status_ind.sv
// tb_led_status_ind: checks led_status_ind against a tick-count pattern model plus literal expectations.
module tb_led_status_ind;
  localparam int TD = 4;
  logic clk = 0, rst = 1, wr_en = 0, sync = 0;
  logic [1:0] wr_ch = 0;
  logic [2:0] wr_mode = 0;
  logic [3:0] wr_count = 0;
  logic [3:0] led;
  logic [2:0] led3;
  logic tick, tick3;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  int m_mode[4], m_cnt[4], m_k[4];
  int m_pre = 0;

  always #5 clk = ~clk;

  led_status_ind #(.N_CH(4), .TICK_DIV(TD), .RST_MODE(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_count(wr_count), .sync(sync), .led(led), .tick(tick));

  // Three channels with a 2-bit address: channel 3 is out of range here.
  led_status_ind #(.N_CH(3), .TICK_DIV(TD), .RST_MODE(2)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_count(wr_count), .sync(sync), .led(led3), .tick(tick3));

  // Level after k ticks since the channel's phase restart.
  function automatic bit lvl(int md, int c, int k);
    int r;
    if (md == 1) return 1;
    if (md == 2) return (k % 10) < 5;
    if (md == 3) return (k % 2) == 0;
    if (md == 4 && c != 0) begin
      r = k % (4 * c + 8);
      return r < 4 * c && (r % 4) < 2;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_led();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = lvl(m_mode[i], m_cnt[i], m_k[i]);
    return e;
  endfunction

  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    bit t;
    t = (m_pre == TD - 1);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 2;
        m_cnt[i] = 0;
        m_k[i] = 0;
      end
      m_pre = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (wr_en && int'(wr_ch) == i) begin
          m_mode[i] = wr_mode > 4 ? 0 : int'(wr_mode);
          m_cnt[i] = int'(wr_count);
          m_k[i] = 0;
        end else if (sync) m_k[i] = 0;
        else if (t) m_k[i]++;
      m_pre = (sync || t) ? 0 : m_pre + 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    logic et;
    if (chk) begin
      e = exp_led();
      et = (m_pre == TD - 1);
      check("tick", {3'b0, tick}, {3'b0, et});
      check("led", led, e);
      check("tick3", {3'b0, tick3}, {3'b0, et});
      check("led3", {1'b0, led3}, {1'b0, e[2:0]});
    end
  end

  initial begin
    cyc(2);
    chk = 1;
    rst = 0;
    check("rst_led", led, 4'b1111);
    check("rst_tick", {3'b0, tick}, 4'd0);
    cyc(3); check("first_tick", {3'b0, tick}, 4'd1);
    cyc(1); check("tick_c4", {3'b0, tick}, 4'd0);
    cyc(16); check("slow_off", led, 4'b0000);
    cyc(20); check("slow_on", led, 4'b1111);
    wr_en = 1; wr_ch = 1; wr_mode = 3; cyc(1);
    wr_en = 0; sync = 1; cyc(1); sync = 0;
    check("sync_led", led, 4'b1111);
    cyc(4); check("fast_off", led, 4'b1101);
    cyc(4); check("fast_on", led, 4'b1111);
    wr_en = 1; wr_ch = 2; wr_mode = 4; wr_count = 3; cyc(1);
    wr_en = 0; sync = 1; cyc(1); sync = 0;
    check("burst_c0", {3'b0, led[2]}, 4'd1);
    cyc(7); check("burst_c7", {3'b0, led[2]}, 4'd1);
    cyc(1); check("burst_c8", {3'b0, led[2]}, 4'd0);
    cyc(8); check("burst_c16", {3'b0, led[2]}, 4'd1);
    cyc(24); check("burst_c40", {3'b0, led[2]}, 4'd0);
    cyc(39); check("burst_c79", {3'b0, led[2]}, 4'd0);
    cyc(1); check("burst_c80", {3'b0, led[2]}, 4'd1);
    cyc(160); check("burst_c240", {3'b0, led[2]}, 4'd1);
    wr_en = 1; wr_ch = 0; wr_mode = 4; wr_count = 0; cyc(1);
    wr_en = 0; check("burst_cnt0", {3'b0, led[0]}, 4'd0);
    wr_en = 1; wr_ch = 3; wr_mode = 6; wr_count = 5; cyc(1);
    wr_en = 0; check("mode6_off", {3'b0, led[3]}, 4'd0);
    cyc(30); check("cnt0_stays", {3'b0, led[0]}, 4'd0);
    wr_en = 1; wr_ch = 3; wr_mode = 1; wr_count = 0; sync = 1; cyc(1);
    wr_en = 0; sync = 0;
    check("wr_sync_led", led, 4'b1110);
    check("wr_sync_tick", {3'b0, tick}, 4'd0);
    cyc(3); check("wr_sync_tick3", {3'b0, tick}, 4'd1);
    cyc(50);
    rst = 1; sync = 1; wr_en = 1; wr_ch = 2; wr_mode = 0; cyc(1);
    rst = 0; sync = 0; wr_en = 0;
    check("mid_rst_led", led, 4'b1111);
    check("mid_rst_tick", {3'b0, tick}, 4'd0);
    cyc(3); check("mid_rst_tick3", {3'b0, tick}, 4'd1);
    cyc(17); check("mid_rst_off", led, 4'b0000);
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
